// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared scan states and display constants.
package seg7_scan_ctrl_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_t;
   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam int         NDIGITS = 4;
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: valid/ready load channel for the display value.
interface seg7_scan_ctrl_if;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   modport master (output load_valid, load_data, input load_ready);
   modport slave  (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl_lzb_mask.sv
// seg7_lzb_mask: flags digits that are zero along with every higher digit.
module seg7_lzb_mask
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0]         digit0,
   input  logic [3:0]         digit1,
   input  logic [3:0]         digit2,
   input  logic [3:0]         digit3,
   input  logic               lzb,
   output logic [NDIGITS-1:0] mask
);
   assign mask[3] = lzb && digit3 == 4'd0;
   assign mask[2] = mask[3] && digit2 == 4'd0;
   assign mask[1] = mask[2] && digit1 == 4'd0;
   assign mask[0] = 1'b0;
   logic unused_d0;
   assign unused_d0 = ^digit0;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 4-digit scan with dead time, LZB and tear-free loads.
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       lzb,
   seg7_scan_ctrl_if.slave            ld,
   output logic [3:0]                 digit0,
   output logic [3:0]                 digit1,
   output logic [3:0]                 digit2,
   output logic [3:0]                 digit3,
   output logic [$clog2(NDIGITS)-1:0] sel,
   output logic [3:0]                 an,
   output logic                       frame_done
);
   localparam int CMAX = DIV > BLANK ? DIV : BLANK;
   localparam int CW   = $clog2(CMAX);
   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   pending;
   logic          pending_full;
   logic [3:0]    mask;
   logic [3:0]    on_an;
   logic          xfer;
   logic          commit;
   seg7_lzb_mask u_mask (
      .digit0 (digit0),
      .digit1 (digit1),
      .digit2 (digit2),
      .digit3 (digit3),
      .lzb    (lzb),
      .mask   (mask)
   );
   assign on_an  = mask[sel] ? AN_OFF : ~(4'b0001 << sel);
   assign xfer   = ld.load_valid && ld.load_ready;
   assign commit = pending_full && (frame_done || state == ST_IDLE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || !enable) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         sel        <= '0;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_BLANK;
               cnt   <= CW'(BLANK - 1);
            end
            ST_BLANK: begin
               if (cnt == '0) begin
                  state <= ST_ON;
                  cnt   <= CW'(DIV - 1);
                  an    <= on_an;
               end else
                  cnt <= cnt - 1'b1;
            end
            ST_ON: begin
               // registered pulse lands on the cycle where cnt reaches zero
               frame_done <= sel == 2'd3 && cnt == CW'(1);
               if (cnt == '0) begin
                  state <= ST_BLANK;
                  cnt   <= CW'(BLANK - 1);
                  sel   <= sel + 1'b1;
                  an    <= AN_OFF;
               end else begin
                  cnt <= cnt - 1'b1;
                  an  <= on_an;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {digit3, digit2, digit1, digit0} <= '0;
         pending                          <= '0;
         pending_full                     <= 1'b0;
         ld.load_ready                    <= 1'b0;
      end else begin
         if (xfer) begin
            pending      <= ld.load_data;
            pending_full <= 1'b1;
         end else if (commit) begin
            {digit3, digit2, digit1, digit0} <= pending;
            pending_full                     <= 1'b0;
         end
         ld.load_ready <= xfer ? 1'b0 : commit ? 1'b1 : !pending_full;
      end
   end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed + random scan checks against a position-based model.
module tb_seg7_scan_ctrl;
   localparam int DIV   = 4;
   localparam int BLANK = 2;
   localparam int P     = DIV + BLANK;
   localparam int FR    = 4 * P;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        lzb = 1'b0;
   logic [3:0]  digit0, digit1, digit2, digit3, an;
   logic [1:0]  sel;
   logic        frame_done;
   int          checks = 0;
   int          failures = 0;
   seg7_scan_ctrl_if lif ();
   seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .lzb        (lzb),
      .ld         (lif),
      .digit0     (digit0),
      .digit1     (digit1),
      .digit2     (digit2),
      .digit3     (digit3),
      .sel        (sel),
      .an         (an),
      .frame_done (frame_done)
   );
   always #5 clk = ~clk;
   // model: outputs follow from cycles elapsed since scanning started
   bit          m_active = 0;
   int          m_t = 0;
   logic [15:0] m_digits = '0, m_pend = '0;
   bit          m_pfull = 0, m_ready = 0;
   logic [3:0]  e_an = 4'hF;
   logic [1:0]  e_sel = '0;
   bit          e_fd = 0;
   bit          idle_pre, xf, cm, sup;
   int          p, d, r;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_t = 0; m_digits = '0; m_pend = '0;
         m_pfull = 0; m_ready = 0; e_an = 4'hF; e_sel = '0; e_fd = 0;
      end else begin
         idle_pre = !m_active;
         xf = lif.load_valid && m_ready;
         cm = m_pfull && (e_fd || idle_pre);
         d  = e_sel;
         sup = lzb && d > 0 && (m_digits >> (4 * d)) == 16'h0;
         if (!enable) begin m_active = 0; m_t = 0; end
         else if (!m_active) begin m_active = 1; m_t = 0; end
         else m_t++;
         if (!m_active) begin
            e_an = 4'hF; e_sel = '0; e_fd = 0;
         end else begin
            p = m_t % FR; d = p / P; r = p % P;
            e_sel = 2'(d);
            e_an  = (r < BLANK || sup) ? 4'hF : 4'hF ^ 4'(1 << d);
            e_fd  = d == 3 && r == P - 1;
         end
         if (xf) begin m_pend = lif.load_data; m_pfull = 1; end
         else if (cm) begin m_digits = m_pend; m_pfull = 0; end
         m_ready = !m_pfull;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      chk("an", {28'd0, an}, {28'd0, e_an});
      chk("sel", {30'd0, sel}, {30'd0, e_sel});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
      chk("digits", {16'd0, digit3, digit2, digit1, digit0}, {16'd0, m_digits});
      chk("load_ready", {31'd0, lif.load_ready}, {31'd0, m_ready});
   endtask
   task automatic wait_fd(input string tag);
      for (int i = 0; i < 3 * FR && !frame_done; i++) tick();
      chk(tag, {31'd0, frame_done}, 32'd1);
   endtask
   task automatic wait_on(input string tag, input logic [1:0] s);
      for (int i = 0; i < 3 * FR && !(sel == s && an == (4'hF ^ 4'(1 << s))); i++) tick();
      chk(tag, {30'd0, sel, an}, {30'd0, s, 4'hF ^ 4'(1 << s)});
   endtask
   task automatic load(input logic [15:0] v);
      lif.load_valid = 1'b1;
      lif.load_data  = v;
      tick();
      lif.load_valid = 1'b0;
   endtask
   int cap;
   initial begin
      lif.load_valid = 1'b0;
      lif.load_data  = '0;
      repeat (3) tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (FR + 6) tick();
      wait_fd("first_frame_done");
      chk("fd_an", {28'd0, an}, 32'h7);
      wait_on("reach_d1", 2'd1);
      load(16'h1234);
      chk("ready_low", {31'd0, lif.load_ready}, 32'd0);
      wait_fd("load_fd");
      chk("digits_old", {16'd0, digit3, digit2, digit1, digit0}, 32'h0);
      tick();
      chk("digits_new", {16'd0, digit3, digit2, digit1, digit0}, 32'h1234);
      chk("ready_back", {31'd0, lif.load_ready}, 32'd1);
      lzb = 1'b1;
      load(16'h0050);
      repeat (2 * FR) tick();
      load(16'h0000);
      repeat (2 * FR) tick();
      lzb = 1'b0;
      wait_fd("abcd_fd");
      tick();
      load(16'hABCD);
      wait_on("reach_d2", 2'd2);
      enable = 1'b0;
      tick();
      chk("idle_an", {28'd0, an}, 32'hF);
      tick();
      chk("idle_load", {16'd0, digit3, digit2, digit1, digit0}, 32'hABCD);
      enable = 1'b1;
      repeat (P + 2) tick();
      wait_on("reach_d2_rst", 2'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_sel", {30'd0, sel}, 32'd0);
      chk("rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      lif.load_valid = 1'b1;
      for (int f = 0; f < 4; f++) begin
         cap = 0;
         for (int i = 0; i < 2 * FR; i++) begin
            lif.load_data = 16'($urandom);
            if (lif.load_ready) cap++;
            tick();
            if (frame_done) break;
         end
         chk("one_capture_per_frame", cap, 32'd1);
      end
      lif.load_valid = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) enable = !enable;
         if ($urandom_range(0, 15) == 0) lzb = !lzb;
         lif.load_valid = $urandom_range(0, 9) == 0;
         lif.load_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
